// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage of a 5-stage MIPS pipeline.
//
// Owns the PC, presents it as the word-aligned fetch address to a
// combinational instruction memory, and loads the returned word into the
// IF/ID pipeline register. Load-use stalls freeze the stage; downstream
// branch/jump redirects reload the PC and leave a single bubble in IF/ID.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   imem_addr         fetch address (always the current PC)
//   imem_instr        instruction returned for imem_addr in the same cycle
//   stall             hold PC, IF/ID and fetch_count
//   redirect_valid    taken branch/jump this cycle (wins over stall)
//   redirect_target   new PC on redirect (low two bits dropped)
//   if_id_valid       IF/ID holds a real instruction (0 = bubble)
//   if_id_instr       registered instruction
//   if_id_pc          registered PC of that instruction
//   if_id_pc_plus4    registered PC+4 (jal link value)
//   fetch_count       number of instructions loaded into IF/ID
//   misalign_err      sticky: a redirect target was not word aligned
//   range_err         sticky: a fetch was accepted from beyond the memory
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] fetch_count,
    output logic        misalign_err,
    output logic        range_err
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

    logic [31:0] pc_q,       pc_d;
    logic        valid_q,    valid_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_pc4_q,   id_pc4_d;
    logic [31:0] count_q,    count_d;
    logic        misalign_q, misalign_d;
    logic        range_q,    range_d;
    logic [31:0] pc_plus4;

    // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0 silently.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        range_d    = range_q;

        if (redirect_valid) begin
            // The instruction fetched this cycle is on the wrong path, so
            // IF/ID becomes a bubble; its data fields are left stale.
            pc_d    = {redirect_target[31:2], 2'b00};
            valid_d = 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (!stall) begin
            instr_d  = imem_instr;
            id_pc_d  = pc_q;
            id_pc4_d = pc_plus4;
            valid_d  = 1'b1;
            pc_d     = pc_plus4;
            count_d  = count_q + 32'd1;
            // Flag but still deliver: the memory aliases on addr[9:2].
            if (pc_q >= IMEM_LIMIT) begin
                range_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd0;
            count_q    <= 32'd0;
            misalign_q <= 1'b0;
            range_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            range_q    <= range_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = id_pc_q;
    assign if_id_pc_plus4 = id_pc4_q;
    assign fetch_count    = count_q;
    assign misalign_err   = misalign_q;
    assign range_err      = range_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] fetch_count;
    logic        misalign_err;
    logic        range_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[9:2]];

    ifetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .fetch_count     (fetch_count),
        .misalign_err    (misalign_err),
        .range_err       (range_err)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk_id;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_cnt;
        logic        e_mis;
        logic        e_rng;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic r, logic s, logic rv, logic [31:0] tgt,
                                logic [31:0] addr, logic v, logic cid,
                                logic [31:0] ins, logic [31:0] pc,
                                logic [31:0] pc4, logic [31:0] cnt,
                                logic mis, logic rng);
        vec_t x;
        x.rst = r; x.stall = s; x.rv = rv; x.tgt = tgt;
        x.e_addr = addr; x.e_valid = v; x.chk_id = cid;
        x.e_instr = ins; x.e_pc = pc; x.e_pc4 = pc4; x.e_cnt = cnt;
        x.e_mis = mis; x.e_rng = rng;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [31:0] tgt);
        rst = r; stall = s; redirect_valid = rv; redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    // Reference model state (plain behavioural rules of the fetch stage).
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_cnt;
    logic        m_valid, m_mis, m_rng;

    task automatic model_step(input logic r, input logic s, input logic rv,
                              input logic [31:0] tgt);
        if (r) begin
            m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0; m_idpc = 32'd0;
            m_idpc4 = 32'd0; m_cnt = 32'd0; m_mis = 1'b0; m_rng = 1'b0;
        end else if (rv) begin
            if (tgt % 4 != 0) m_mis = 1'b1;
            m_pc = tgt - (tgt % 4);
            m_valid = 1'b0;
        end else if (!s) begin
            m_instr = mem[(m_pc / 4) % 256];
            m_idpc  = m_pc;
            m_idpc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            if (m_pc >= 32'd1024) m_rng = 1'b1;
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0]  = 32'h2008_0005;
        mem[1]  = 32'h2009_000A;
        mem[2]  = 32'h0109_5020;
        mem[5]  = 32'h0168_6020;
        mem[6]  = 32'h118A_0002;
        mem[10] = 32'h200E_0063;
        mem[12] = 32'h200F_0007;

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;

        //            rst stl rv  tgt           addr          v  id instr         pc            pc4           cnt mis rng
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        32'h0,        32'h0,        0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h4,        1, 1, 32'h2008_0005, 32'h0,       32'h4,        1,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h8,        1, 1, 32'h2009_000A, 32'h4,       32'h8,        2,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'hC,        1, 1, 32'h0109_5020, 32'h8,       32'hC,        3,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h10,       1, 1, 32'hA500_0003, 32'hC,       32'h10,       4,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h14,       1, 1, 32'hA500_0004, 32'h10,      32'h14,       5,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h18,       1, 1, 32'h0168_6020, 32'h14,      32'h18,       6,  0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h18,       1, 1, 32'h0168_6020, 32'h14,      32'h18,       6,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h1C,       1, 1, 32'h118A_0002, 32'h18,      32'h1C,       7,  0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h30,       32'h30,       0, 0, 32'h0,        32'h0,        32'h0,        7,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h34,       1, 1, 32'h200F_0007, 32'h30,      32'h34,       8,  0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h28,       32'h28,       0, 0, 32'h0,        32'h0,        32'h0,        8,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h2C,       1, 1, 32'h200E_0063, 32'h28,      32'h2C,       9,  0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h32,       32'h30,       0, 0, 32'h0,        32'h0,        32'h0,        9,  1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h34,       1, 0, 32'h0,        32'h0,        32'h0,        10, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h38,       1, 0, 32'h0,        32'h0,        32'h0,        11, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h3C,       1, 0, 32'h0,        32'h0,        32'h0,        12, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h40,       1, 0, 32'h0,        32'h0,        32'h0,        13, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h44,       1, 0, 32'h0,        32'h0,        32'h0,        14, 1, 0));
        vecs.push_back(mk(1, 1, 1, 32'h77,       32'h0,        0, 1, 32'h0,        32'h0,        32'h0,        0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h3FC,      32'h3FC,      0, 0, 32'h0,        32'h0,        32'h0,        0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h400,      1, 1, 32'hA500_00FF, 32'h3FC,     32'h400,      1,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h404,      1, 1, 32'h2008_0005, 32'h400,     32'h404,      2,  0, 1));
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h0,        32'h0,        2,  0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, 1, 32'hA500_00FF, 32'hFFFF_FFFC, 32'h0,      3,  0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h10,       32'h10,       0, 0, 32'h0,        32'h0,        32'h0,        3,  0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h20,       32'h20,       0, 0, 32'h0,        32'h0,        32'h0,        3,  0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h24,       1, 1, 32'hA500_0008, 32'h20,      32'h24,       4,  0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].tgt);
            chk($sformatf("vec%0d.addr", i),  imem_addr,           vecs[i].e_addr);
            chk($sformatf("vec%0d.valid", i), 32'(if_id_valid),    32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.count", i), fetch_count,         vecs[i].e_cnt);
            chk($sformatf("vec%0d.mis", i),   32'(misalign_err),   32'(vecs[i].e_mis));
            chk($sformatf("vec%0d.rng", i),   32'(range_err),      32'(vecs[i].e_rng));
            if (vecs[i].chk_id) begin
                chk($sformatf("vec%0d.instr", i), if_id_instr,    vecs[i].e_instr);
                chk($sformatf("vec%0d.pc", i),    if_id_pc,       vecs[i].e_pc);
                chk($sformatf("vec%0d.pc4", i),   if_id_pc_plus4, vecs[i].e_pc4);
            end
        end

        // Hand sequence: a long stall holds everything, then release.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        chk("stall_hold.addr",  imem_addr,   32'h4);
        chk("stall_hold.count", fetch_count, 32'd1);
        chk("stall_hold.instr", if_id_instr, 32'h2008_0005);
        step(0, 0, 0, 0);
        chk("stall_rel.instr",  if_id_instr, 32'h2009_000A);
        chk("stall_rel.count",  fetch_count, 32'd2);

        // Randomized run against the behavioural model.
        step(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, rv;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0:       tgt = $urandom();
                1:       tgt = 32'($urandom_range(0, 300)) * 4 + 32'($urandom_range(1, 3));
                2:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
                default: tgt = 32'($urandom_range(0, 300)) * 4;
            endcase
            step(r, s, rv, tgt);
            model_step(r, s, rv, tgt);
            chk("rnd.addr",  imem_addr,         m_pc);
            chk("rnd.valid", 32'(if_id_valid),  32'(m_valid));
            chk("rnd.count", fetch_count,       m_cnt);
            chk("rnd.mis",   32'(misalign_err), 32'(m_mis));
            chk("rnd.rng",   32'(range_err),    32'(m_rng));
            if (m_valid) begin
                chk("rnd.instr", if_id_instr,    m_instr);
                chk("rnd.pc",    if_id_pc,       m_idpc);
                chk("rnd.pc4",   if_id_pc_plus4, m_idpc4);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage (IF) of the 5-stage MIPS pipeline.
- It is the initiator side of the instruction-memory interface. It owns the PC and drives the word-aligned fetch address to the instruction memory, which is combinational, 256 words, indexed by addr[9:2].
- It captures the returned instruction into the IF/ID pipeline register.
- It handles load-use stalls from the hazard unit and branch/jump redirects (beq, j, jal, jr) resolved downstream, inserting a bubble on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- IMEM_WORDS, 256, instruction-memory depth in words; used only for the out-of-range flag.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  fetch address, always equal to the current PC.
- imem_instr  input  32  instruction returned combinationally for imem_addr in the same cycle.
- stall  input  1  hazard-unit hold request (load-use); freezes PC and IF/ID.
- redirect_valid  input  1  taken branch/jump resolved this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- if_id_valid  output  1  IF/ID register holds a real instruction; 0 means bubble.
- if_id_instr  output  32  registered instruction.
- if_id_pc  output  32  registered PC of that instruction.
- if_id_pc_plus4  output  32  registered PC+4 (jal link value source).
- fetch_count  output  32  number of instructions delivered into IF/ID (valid loads).
- misalign_err  output  1  sticky: a redirect target had bits [1:0] != 0.
- range_err  output  1  sticky: the PC was at or above IMEM_WORDS*4 while a fetch was accepted.

Behaviour:
- Single clock. Reset is synchronous and active-high. Everything is sampled on the rising edge of clk.
- Reset values:
  - PC = RESET_PC, so imem_addr = RESET_PC.
  - if_id_valid = 0, if_id_instr = 0, if_id_pc = 0, if_id_pc_plus4 = 0.
  - fetch_count = 0, misalign_err = 0, range_err = 0.
- imem_addr = PC combinationally. No other logic is in the path; the instruction returns in the same cycle with zero-wait latency.
- Per-edge priority is rst > redirect_valid > stall > normal.
- rst: full reset as above, regardless of the other inputs. Reset mid-operation discards IF/ID contents.
- Redirect (redirect_valid=1, stall ignored):
  - PC <= {redirect_target[31:2], 2'b00}.
  - if_id_valid <= 0; if_id_instr/pc/pc_plus4 may hold stale values and must be ignored downstream.
  - fetch_count is unchanged.
  - If redirect_target[1:0] != 0, set misalign_err.
  - Redirect penalty: exactly one bubble in IF/ID. The target instruction appears in IF/ID on the second edge after redirect_valid is sampled.
- Stall (redirect_valid=0, stall=1):
  - PC, all IF/ID fields and fetch_count hold.
  - imem_addr is unchanged, so the same instruction is re-fetched next cycle.
- Normal (redirect_valid=0, stall=0):
  - if_id_instr <= imem_instr, if_id_pc <= PC, if_id_pc_plus4 <= PC+4, if_id_valid <= 1.
  - PC <= PC+4; fetch_count <= fetch_count+1.
  - If PC >= IMEM_WORDS*4, set range_err. The fetch still proceeds.
- Arithmetic:
  - PC+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0 with no flag.
  - fetch_count wraps at 2^32.
- An all-zero instruction (nop) is a valid instruction: if_id_valid=1 and it is counted.
- Sticky flags clear only on rst.
- Consecutive redirects on back-to-back cycles: each redirect takes effect and if_id_valid stays 0 for every such cycle.
- Stall deasserting in the same cycle a redirect is asserted follows redirect behaviour.

Test Plan:
- Reset then run 3 free cycles with the imem holding the standard test program:
  - After rst: imem_addr=0, if_id_valid=0.
  - Edge 1: if_id_instr=0x20080005, if_id_pc=0, PC=4.
  - Edge 2: if_id_instr=0x2009000A.
  - Edge 3: if_id_instr=0x01095020, if_id_pc_plus4=0xC, fetch_count=3.
- Load-use stall:
  - Hold stall=1 for 1 cycle when PC=0x18 and IF/ID holds the instruction at 0x14 (0x01686020).
  - Required: PC stays 0x18, IF/ID stays 0x01686020/0x14, fetch_count unchanged.
  - Next free edge: if_id_instr=0x118A0002, if_id_pc=0x18.
- jal redirect:
  - redirect_valid=1, target=0x30.
  - Next cycle: imem_addr=0x30, if_id_valid=0.
  - Following edge: if_id_instr=0x200F0007, if_id_pc=0x30, if_id_pc_plus4=0x34.
- Redirect with simultaneous stall=1, target=0x28:
  - Redirect wins: PC=0x28, if_id_valid=0.
  - Next free edge: if_id_instr=0x200E0063.
- Misaligned target 0x32:
  - PC=0x30, misalign_err=1, and it stays 1 across 5 further cycles.
  - rst clears it to 0 and PC returns to 0.
- Out-of-range fetch:
  - Redirect to 0x3FC: the fetch is accepted and range_err stays 0.
  - The next fetch at PC=0x400 sets range_err=1.
  - Redirect to 0xFFFF_FFFC, then one free edge: PC wraps to 0x0.
